// File: rtl/mem_pkg.sv
// Shared widths, X/M control-word bit positions and FSM encoding for the memory stage.
package mem_pkg;

  localparam int unsigned CTRL_W      = 14;
  localparam int unsigned CTRL_MEM_RE = 3;
  localparam int unsigned CTRL_MEM_WE = 4;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned RD_W        = 5;
  localparam int unsigned STATE_W     = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam state_t ST_ERR  = 2'd3;

  function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_RE] | ctrl[CTRL_MEM_WE];
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for an outstanding data-memory request: clear on issue, count while waiting,
// flag when the count reaches TIMEOUT-1.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: runs the dmem req/ack handshake, stalls upstream while busy,
// and strobes out_valid into the M/W latch. Optional WM_BYPASS_EN forwards W-stage data into stores.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CTRL_W-1:0]   in_ctrl_signals,
  input  logic [DATA_W-1:0]   in_ALU_result,
  input  logic [DATA_W-1:0]   in_data_reg,
  input  logic [RD_W-1:0]     in_rd,
  input  logic [DATA_W-1:0]   in_PC_next,
`ifdef WM_BYPASS_EN
  input  logic                wb_regwrite,
  input  logic [RD_W-1:0]     wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
`endif
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                mem_stall,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_mem_data,
  output logic [DATA_W-1:0]   out_ALU_result,
  output logic [CTRL_W-1:0]   out_ctrl_signals,
  output logic [RD_W-1:0]     out_rd,
  output logic [DATA_W-1:0]   out_PC_next,
  output logic                mem_err
);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_we;
  logic                w_mem_op;
  logic                w_capture;
  logic                w_expire;
  logic                w_ctr_clr;
  logic                w_ctr_inc;
  logic                w_stall;
  logic                w_valid;
  logic                w_req;
  logic                w_err;
  logic [DATA_W-1:0]   w_wdata;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem_data;

  // A store wins when both the read and write bits are set.
  assign w_we      = in_ctrl_signals[CTRL_MEM_WE];
  assign w_mem_op  = is_mem_op(in_ctrl_signals);
  assign w_capture = (r_state == ST_IDLE) && w_mem_op;

`ifdef WM_BYPASS_EN
  assign w_wdata = (wb_regwrite && (wb_rd != '0) && (wb_rd == in_rd) && w_we) ? wb_data
                                                                              : in_data_reg;
`else
  assign w_wdata = in_data_reg;
`endif

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .i_clr    (w_ctr_clr),
    .i_inc    (w_ctr_inc),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_mem_op) w_next_state = ST_REQ;
      ST_REQ: begin
        if (dmem_ack) begin
          w_next_state = ST_DONE;
        end else if (w_expire) begin
          w_next_state = ST_ERR;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      ST_ERR:  w_next_state = ST_ERR;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stall   = 1'b0;
    w_valid   = 1'b0;
    w_req     = 1'b0;
    w_err     = 1'b0;
    w_ctr_clr = 1'b0;
    w_ctr_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall   = w_mem_op;
        w_valid   = ~w_mem_op;
        w_ctr_clr = w_mem_op;
      end
      ST_REQ: begin
        w_req     = 1'b1;
        w_stall   = 1'b1;
        w_ctr_inc = ~dmem_ack;
      end
      ST_DONE: w_valid = 1'b1;
      ST_ERR: begin
        w_err   = 1'b1;
        w_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are frozen at issue so they stay stable for the whole handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_data <= '0;
    end else begin
      if (w_capture) begin
        r_we    <= w_we;
        r_addr  <= in_ALU_result[ADDR_W-1:0];
        r_wdata <= w_wdata;
      end
      if ((r_state == ST_REQ) && dmem_ack && !r_we) begin
        r_mem_data <= dmem_rdata;
      end
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = w_err;
  assign mem_stall  = w_stall & ~reset;
  assign out_valid  = w_valid & ~reset;

  assign out_mem_data     = r_mem_data;
  assign out_ALU_result   = in_ALU_result;
  assign out_ctrl_signals = in_ctrl_signals;
  assign out_rd           = in_rd;
  assign out_PC_next      = in_PC_next;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: loads, stores, timeout, async reset and,
// when WM_BYPASS_EN is defined, store-data forwarding.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [CTRL_W-1:0] C_RE  = CTRL_W'(1) << CTRL_MEM_RE;
  localparam logic [CTRL_W-1:0] C_WE  = CTRL_W'(1) << CTRL_MEM_WE;
  localparam logic [CTRL_W-1:0] C_ALU = 14'h0005;
  localparam logic [CTRL_W-1:0] C_EXT = 14'h0100;

  typedef struct {
    logic [31:0]       mem_data;
    logic [31:0]       alu;
    logic [4:0]        rd;
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  logic              clock;
  logic              reset;
  logic [CTRL_W-1:0] in_ctrl_signals;
  logic [31:0]       in_ALU_result;
  logic [31:0]       in_data_reg;
  logic [4:0]        in_rd;
  logic [31:0]       in_PC_next;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  logic              mem_stall;
  logic              out_valid;
  logic [31:0]       out_mem_data;
  logic [31:0]       out_ALU_result;
  logic [CTRL_W-1:0] out_ctrl_signals;
  logic [4:0]        out_rd;
  logic [31:0]       out_PC_next;
  logic              mem_err;
`ifdef WM_BYPASS_EN
  logic              wb_regwrite;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [31:0] model_mem;

  mem_stage #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_ctrl_signals  (in_ctrl_signals),
    .in_ALU_result    (in_ALU_result),
    .in_data_reg      (in_data_reg),
    .in_rd            (in_rd),
    .in_PC_next       (in_PC_next),
`ifdef WM_BYPASS_EN
    .wb_regwrite      (wb_regwrite),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
`endif
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_ack         (dmem_ack),
    .dmem_rdata       (dmem_rdata),
    .mem_stall        (mem_stall),
    .out_valid        (out_valid),
    .out_mem_data     (out_mem_data),
    .out_ALU_result   (out_ALU_result),
    .out_ctrl_signals (out_ctrl_signals),
    .out_rd           (out_rd),
    .out_PC_next      (out_PC_next),
    .mem_err          (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one memory op at a falling edge, serve it after ack_dly REQ cycles, score the result.
  task automatic mem_op(input string tag, input logic [CTRL_W-1:0] ctrl, input logic [31:0] alu,
                        input logic [31:0] sdata, input logic [4:0] rd, input int ack_dly,
                        input logic [31:0] rdata, input logic [31:0] exp_wdata);
    exp_t e;
    int   stalls;
    int   reqs;
    bit   done;
    logic is_wr;
    is_wr           = ctrl[CTRL_MEM_WE];
    in_ctrl_signals = ctrl;
    in_ALU_result   = alu;
    in_data_reg     = sdata;
    in_rd           = rd;
    in_PC_next      = alu + 32'd4;
    if (!is_wr) model_mem = rdata;
    e.mem_data = model_mem;
    e.alu      = alu;
    e.rd       = rd;
    e.pc       = alu + 32'd4;
    e.ctrl     = ctrl;
    sb.push_back(e);
    #1;
    check({tag, "_issue_stall"}, 32'(mem_stall), 32'd1);
    check({tag, "_issue_valid"}, 32'(out_valid), 32'd0);
    stalls = 1;
    reqs   = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clock);
      if (out_valid) begin
        check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        e = sb.pop_front();
        check({tag, "_mem_data"}, out_mem_data, e.mem_data);
        check({tag, "_alu_pass"}, out_ALU_result, e.alu);
        check({tag, "_rd_pass"}, 32'(out_rd), 32'(e.rd));
        check({tag, "_pc_pass"}, out_PC_next, e.pc);
        check({tag, "_ctrl_pass"}, 32'(out_ctrl_signals), 32'(e.ctrl));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(ack_dly + 1));
        check({tag, "_req_cycles"}, 32'(reqs), 32'(ack_dly));
        check({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
        done = 1'b1;
      end else begin
        if (mem_stall) stalls++;
        if (dmem_req) begin
          reqs++;
          check({tag, "_addr"}, 32'(dmem_addr), 32'(alu[ADDR_W-1:0]));
          check({tag, "_we"}, 32'(dmem_we), 32'(is_wr));
          check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        end
      end
      dmem_ack   = dmem_req && !done && (reqs == ack_dly);
      dmem_rdata = rdata;
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    dmem_ack        = 1'b0;
    in_ctrl_signals = '0;
    @(negedge clock);
  endtask

  initial begin
    int reqs;
    reset           = 1'b1;
    in_ctrl_signals = C_RE;
    in_ALU_result   = 32'h0000_0123;
    in_data_reg     = 32'h0;
    in_rd           = 5'd0;
    in_PC_next      = 32'h0;
    dmem_ack        = 1'b0;
    dmem_rdata      = 32'h0;
    model_mem       = 32'h0;
`ifdef WM_BYPASS_EN
    wb_regwrite     = 1'b0;
    wb_rd           = 5'd0;
    wb_data         = 32'h0;
`endif
    @(negedge clock);
    @(negedge clock);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", 32'(dmem_addr), 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_mem_data", out_mem_data, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    reset           = 1'b0;
    in_ctrl_signals = '0;
    @(negedge clock);

    // ALU op completes in the same cycle; a stray ack in IDLE is ignored.
    in_ctrl_signals = C_ALU;
    in_ALU_result   = 32'h0000_0055;
    #1;
    check("alu_valid", 32'(out_valid), 32'd1);
    check("alu_stall", 32'(mem_stall), 32'd0);
    check("alu_req", 32'(dmem_req), 32'd0);
    check("alu_pass", out_ALU_result, 32'h0000_0055);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_1111;
    @(negedge clock);
    dmem_ack   = 1'b0;
    check("stray_ack_req", 32'(dmem_req), 32'd0);
    check("stray_ack_mem", out_mem_data, 32'd0);
    check("stray_ack_valid", 32'(out_valid), 32'd1);
    in_ctrl_signals = '0;
    @(negedge clock);

    mem_op("ld1", C_RE | C_EXT, 32'h0000_0010, 32'h0, 5'd3, 1, 32'hDEAD_BEEF, 32'h0);
    mem_op("st1", C_WE, 32'h0000_0ABC, 32'h1234_5678, 5'd0, 5, 32'h0BAD_0BAD, 32'h1234_5678);
    mem_op("rw", C_RE | C_WE, 32'h0000_02F0, 32'hA5A5_A5A5, 5'd7, 2, 32'h7777_7777,
           32'hA5A5_A5A5);
    mem_op("ld2", C_RE, 32'h0001_2345, 32'h5555_0000, 5'd9, 3, 32'h600D_F00D, 32'h5555_0000);

    // No ack: exactly TIMEOUT request cycles, then ERR sticks until reset.
    in_ctrl_signals = C_RE;
    in_ALU_result   = 32'h0000_0044;
    reqs = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clock);
      if (mem_err) break;
      if (dmem_req) reqs++;
    end
    check("to_req_cycles", 32'(reqs), 32'(TIMEOUT));
    check("to_err", 32'(mem_err), 32'd1);
    check("to_req_low", 32'(dmem_req), 32'd0);
    check("to_stall", 32'(mem_stall), 32'd1);
    in_ctrl_signals = '0;
    dmem_ack        = 1'b1;
    dmem_rdata      = 32'h9999_9999;
    @(negedge clock);
    dmem_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("err_sticky", 32'(mem_err), 32'd1);
    check("err_stall_sticky", 32'(mem_stall), 32'd1);
    check("err_valid", 32'(out_valid), 32'd0);
    check("err_mem_data", out_mem_data, model_mem);
    reset = 1'b1;
    #1;
    check("err_clr_err", 32'(mem_err), 32'd0);
    check("err_clr_stall", 32'(mem_stall), 32'd0);
    check("err_clr_mem", out_mem_data, 32'd0);
    model_mem = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Async reset in REQ abandons the access without a clock edge.
    in_ctrl_signals = C_RE;
    in_ALU_result   = 32'h0000_0080;
    @(negedge clock);
    check("mid_req_up", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_req_drop", 32'(dmem_req), 32'd0);
    check("mid_req_stall", 32'(mem_stall), 32'd0);
    check("mid_req_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset           = 1'b0;
    in_ctrl_signals = '0;
    @(negedge clock);
    mem_op("ld3", C_RE, 32'h0000_0090, 32'h0, 5'd1, 2, 32'h0BAD_CAFE, 32'h0);

`ifdef WM_BYPASS_EN
    wb_regwrite = 1'b1;
    wb_rd       = 5'd5;
    wb_data     = 32'hCAFE_0000;
    mem_op("byp_hit", C_WE, 32'h0000_0100, 32'h1111_2222, 5'd5, 1, 32'h0, 32'hCAFE_0000);
    wb_rd = 5'd0;
    mem_op("byp_r0", C_WE, 32'h0000_0104, 32'h3333_4444, 5'd0, 1, 32'h0, 32'h3333_4444);
    wb_regwrite = 1'b0;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
